// File: rtl/alu_pkg.sv
// Shared opcode encoding for the RV32-style execute-stage ALU.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_XOR    = 4'b0011,
    ALU_SLL    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_SUB    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_SLT    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_MUL    = 4'b1010,
    ALU_MULH   = 4'b1011,
    ALU_MULHSU = 4'b1100,
    ALU_MULHU  = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; other opcodes yield 0.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [width-1:0]         value,
  input  logic [$clog2(width)-1:0] shamt,
  input  alu_op_e                  op,
  output logic [width-1:0]         shifted
);

  logic signed [width-1:0] value_s;
  logic        [width-1:0] sra_res;

  assign value_s = value;
  assign sra_res = value_s >>> shamt;

  always_comb begin
    shifted = '0;
    case (op)
      ALU_SLL: shifted = value << shamt;
      ALU_SRL: shifted = value >> shamt;
      ALU_SRA: shifted = sra_res;
      default: shifted = '0;
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Registered 32-bit ALU with branch compare flags.
// Define ALU_MUL_EN to add the RV32M multiply opcodes (1010-1101).
module alu_core
  import alu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [width-1:0]      rs1,
  input  logic [width-1:0]      rs2_MUX,
  input  logic [ALU_CTRL_W-1:0] ALUCtrl,
  output logic                  out_valid,
  output logic [width-1:0]      alu_out,
  output logic                  zero,
  output logic                  lt,
  output logic                  ltu
);

  localparam int SHW = $clog2(width);

  alu_op_e          op;
  logic [width-1:0] shift_res;
  logic [width-1:0] result;
  logic             lt_c;
  logic             ltu_c;

  assign op    = alu_op_e'(ALUCtrl);
  assign lt_c  = $signed(rs1) < $signed(rs2_MUX);
  assign ltu_c = rs1 < rs2_MUX;

  alu_shifter #(.width(width)) u_shifter (
    .value  (rs1),
    .shamt  (rs2_MUX[SHW-1:0]),
    .op     (op),
    .shifted(shift_res)
  );

`ifdef ALU_MUL_EN
  // Operands are extended to 2*width so one unsigned multiply per signedness
  // combination yields the exact low 2*width bits of the true product.
  logic [2*width-1:0] prod_ss;
  logic [2*width-1:0] prod_su;
  logic [2*width-1:0] prod_uu;

  assign prod_ss = {{width{rs1[width-1]}}, rs1} * {{width{rs2_MUX[width-1]}}, rs2_MUX};
  assign prod_su = {{width{rs1[width-1]}}, rs1} * {{width{1'b0}}, rs2_MUX};
  assign prod_uu = {{width{1'b0}}, rs1} * {{width{1'b0}}, rs2_MUX};
`endif

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = rs1 & rs2_MUX;
      ALU_OR:   result = rs1 | rs2_MUX;
      ALU_ADD:  result = rs1 + rs2_MUX;
      ALU_XOR:  result = rs1 ^ rs2_MUX;
      ALU_SUB:  result = rs1 - rs2_MUX;
      ALU_SLL, ALU_SRL, ALU_SRA: result = shift_res;
      ALU_SLT:  result = {{(width-1){1'b0}}, lt_c};
      ALU_SLTU: result = {{(width-1){1'b0}}, ltu_c};
`ifdef ALU_MUL_EN
      ALU_MUL:    result = prod_uu[width-1:0];
      ALU_MULH:   result = prod_ss[2*width-1:width];
      ALU_MULHSU: result = prod_su[2*width-1:width];
      ALU_MULHU:  result = prod_uu[2*width-1:width];
`endif
      default:  result = '0;
    endcase
  end

  // Result and flags hold while idle; only out_valid follows in_valid every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero      <= 1'b1;
      lt        <= 1'b0;
      ltu       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_out <= result;
        zero    <= (result == '0);
        lt      <= lt_c;
        ltu     <= ltu_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core; expected results are queued at drive time.
// Build with ALU_MUL_EN defined to cover the multiply opcodes.
module tb_alu_core;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        ltu;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] rs1;
  logic [31:0] rs2_MUX;
  logic [3:0]  ALUCtrl;
  logic        out_valid;
  logic [31:0] alu_out;
  logic        zero;
  logic        lt;
  logic        ltu;

  int   checks;
  int   errors;
  txn_t stim[$];
  txn_t sb[$];

  alu_core #(.width(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .rs1      (rs1),
    .rs2_MUX  (rs2_MUX),
    .ALUCtrl  (ALUCtrl),
    .out_valid(out_valid),
    .alu_out  (alu_out),
    .zero     (zero),
    .lt       (lt),
    .ltu      (ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_txn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] res, input logic z, input logic l, input logic lu);
    txn_t t;
    t.a = a; t.b = b; t.op = op; t.res = res; t.z = z; t.lt = l; t.ltu = lu;
    stim.push_back(t);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; rs1 = 32'h5; rs2_MUX = 32'h3; ALUCtrl = 4'b0010;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, alu_out, zero, lt, ltu} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset: got v=%0b out=%h z=%0b lt=%0b ltu=%0b, want v=0 out=0 z=1 lt=0 ltu=0",
               out_valid, alu_out, zero, lt, ltu);
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_arith_logic();
    int n;
    txn_t t, e;
    add_txn(32'h5,        32'h3,        4'b0010, 32'h8,        1'b0, 1'b0, 1'b0);
    add_txn(32'hA,        32'h3,        4'b0110, 32'h7,        1'b0, 1'b0, 1'b0);
    add_txn(32'hA,        32'hA,        4'b0110, 32'h0,        1'b1, 1'b0, 1'b0);
    add_txn(32'hFFFFFFFF, 32'h1,        4'b0010, 32'h0,        1'b1, 1'b1, 1'b0);
    add_txn(32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0000, 32'h0,        1'b1, 1'b1, 1'b0);
    add_txn(32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    add_txn(32'hAAAAAAAA, 32'h55555555, 4'b0011, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    n = stim.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if ({out_valid, alu_out, zero, lt, ltu} !== {1'b1, e.res, e.z, e.lt, e.ltu}) begin
          errors++;
          $display("[TB] FAIL arith_logic[%0d]: got v=%0b out=%h z=%0b lt=%0b ltu=%0b, want v=1 out=%h z=%0b lt=%0b ltu=%0b",
                   i-1, out_valid, alu_out, zero, lt, ltu, e.res, e.z, e.lt, e.ltu);
        end
      end
      if (i < n) begin
        t = stim.pop_front();
        rs1 = t.a; rs2_MUX = t.b; ALUCtrl = t.op; in_valid = 1'b1;
        sb.push_back(t);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_shift_compare();
    int n;
    txn_t t, e;
    add_txn(32'h1,        32'h4,        4'b0100, 32'h10,       1'b0, 1'b1, 1'b1);
    add_txn(32'h80000000, 32'h1,        4'b0101, 32'h40000000, 1'b0, 1'b1, 1'b0);
    add_txn(32'h80000000, 32'h1,        4'b0111, 32'hC0000000, 1'b0, 1'b1, 1'b0);
    add_txn(32'h1,        32'h21,       4'b0100, 32'h2,        1'b0, 1'b1, 1'b1);
    add_txn(32'h80000000, 32'h3F,       4'b0111, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    add_txn(32'hFFFFFFFE, 32'h1,        4'b1000, 32'h1,        1'b0, 1'b1, 1'b0);
    add_txn(32'h1,        32'hFFFFFFFF, 4'b1001, 32'h1,        1'b0, 1'b0, 1'b1);
    add_txn(32'h1,        32'hFFFFFFFF, 4'b1000, 32'h0,        1'b1, 1'b0, 1'b1);
    n = stim.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if ({out_valid, alu_out, zero, lt, ltu} !== {1'b1, e.res, e.z, e.lt, e.ltu}) begin
          errors++;
          $display("[TB] FAIL shift_compare[%0d]: got v=%0b out=%h z=%0b lt=%0b ltu=%0b, want v=1 out=%h z=%0b lt=%0b ltu=%0b",
                   i-1, out_valid, alu_out, zero, lt, ltu, e.res, e.z, e.lt, e.ltu);
        end
      end
      if (i < n) begin
        t = stim.pop_front();
        rs1 = t.a; rs2_MUX = t.b; ALUCtrl = t.op; in_valid = 1'b1;
        sb.push_back(t);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_default_mul();
    int n;
    txn_t t, e;
    add_txn(32'h5,        32'h3, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b0);
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1110, 32'h0,        1'b1, 1'b1, 1'b0);
`ifdef ALU_MUL_EN
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1010, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1011, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1101, 32'h00000001, 1'b0, 1'b1, 1'b0);
`else
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1010, 32'h0,        1'b1, 1'b1, 1'b0);
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1011, 32'h0,        1'b1, 1'b1, 1'b0);
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1100, 32'h0,        1'b1, 1'b1, 1'b0);
    add_txn(32'hFFFFFFFF, 32'h2, 4'b1101, 32'h0,        1'b1, 1'b1, 1'b0);
`endif
    n = stim.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if ({out_valid, alu_out, zero, lt, ltu} !== {1'b1, e.res, e.z, e.lt, e.ltu}) begin
          errors++;
          $display("[TB] FAIL default_mul[%0d]: got v=%0b out=%h z=%0b lt=%0b ltu=%0b, want v=1 out=%h z=%0b lt=%0b ltu=%0b",
                   i-1, out_valid, alu_out, zero, lt, ltu, e.res, e.z, e.lt, e.ltu);
        end
      end
      if (i < n) begin
        t = stim.pop_front();
        rs1 = t.a; rs2_MUX = t.b; ALUCtrl = t.op; in_valid = 1'b1;
        sb.push_back(t);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    rs1 = 32'h5; rs2_MUX = 32'h3; ALUCtrl = 4'b0010; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, alu_out, zero} !== {1'b1, 32'h8, 1'b0}) begin
      errors++;
      $display("[TB] FAIL hold_load: got v=%0b out=%h z=%0b, want v=1 out=00000008 z=0",
               out_valid, alu_out, zero);
    end
    in_valid = 1'b0; rs1 = 32'h80000000; rs2_MUX = 32'h1; ALUCtrl = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, alu_out, zero, lt, ltu} !== {1'b0, 32'h8, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL hold[%0d]: got v=%0b out=%h z=%0b lt=%0b ltu=%0b, want v=0 out=00000008 z=0 lt=0 ltu=0",
                 i, out_valid, alu_out, zero, lt, ltu);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rs1 = 32'h80000000; rs2_MUX = 32'h1; ALUCtrl = 4'b0010; in_valid = 1'b1;
    @(negedge clk);
    rs1 = 32'h7; rs2_MUX = 32'h9; ALUCtrl = 4'b0001;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, alu_out, zero, lt, ltu} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got v=%0b out=%h z=%0b lt=%0b ltu=%0b, want v=0 out=0 z=1 lt=0 ltu=0",
               out_valid, alu_out, zero, lt, ltu);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, alu_out, zero} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_hold: got v=%0b out=%h z=%0b, want v=0 out=0 z=1",
               out_valid, alu_out, zero);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith_logic();
    test_shift_compare();
    test_default_mul();
    test_hold();
    test_async_reset();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the RV32-style execute stage; operand B already passes through the immediate/register mux (rs2_MUX).
- Computes one of ten arithmetic/logic/shift/compare operations selected by a 4-bit ALUCtrl, plus zero/lt/ltu flags for branch resolution.
- Result and flags are registered: one-cycle latency from in_valid to out_valid.

Parameters:
- width, 32, datapath width in bits; must be a power of two ≥ 8; shift amount is rs2_MUX[$clog2(width)-1:0].

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operands/ALUCtrl valid this cycle.
- rs1  in  width  operand A.
- rs2_MUX  in  width  operand B (register or immediate).
- ALUCtrl  in  4  operation select.
- out_valid  out  1  registered in_valid.
- alu_out  out  width  registered result.
- zero  out  1  registered (result == 0).
- lt  out  1  registered signed rs1 < rs2_MUX.
- ltu  out  1  registered unsigned rs1 < rs2_MUX.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: alu_out=0, zero=1, lt=0, ltu=0, out_valid=0. Asserting rst mid-operation discards any pending result immediately.
- Each rising clk with in_valid=1: alu_out, zero, lt and ltu load from the combinational result of the current inputs; out_valid<=1.
- With in_valid=0: result and flag registers hold; out_valid<=0.
- ALUCtrl encoding:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD, modulo 2^width; carry discarded.
  - 0011 XOR.
  - 0100 SLL.
  - 0101 SRL, zero-fill.
  - 0110 SUB, rs1-rs2_MUX modulo 2^width.
  - 0111 SRA, sign-fill from rs1[width-1].
  - 1000 SLT, signed: result = {0…,1} if rs1<rs2_MUX, else 0.
  - 1001 SLTU, unsigned, same result form.
  - 1010–1111: result 0, except where claimed by the optional feature.
- Shifts use only the low $clog2(width) bits of rs2_MUX; upper bits are ignored (shift by 33 == shift by 1).
- zero is computed from the final selected result for every opcode, including the default (undefined opcode gives zero=1).
- lt and ltu are computed from the operands on every valid cycle, independent of ALUCtrl.
- No overflow or exception outputs; no X propagation: all undefined opcodes drive 0.

Optional Feature:
- Macro ALU_MUL_EN. When defined, opcodes add RV32M multiply, single-cycle combinational into the same output register (latency unchanged):
  - 1010 MUL: low width bits of the product.
  - 1011 MULH: high half, signed×signed.
  - 1100 MULHSU: high half, signed rs1 × unsigned rs2_MUX.
  - 1101 MULHU: high half, unsigned×unsigned.
- 1110/1111 remain 0.
- When not defined: 1010–1101 behave as undefined opcodes (result 0, zero=1), and no multiplier logic is synthesized.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_op_e for the codes above (ALU_AND … ALU_SLTU, ALU_MUL … ALU_MULHU).
  - Constant ALU_CTRL_W=4.
- One sub-module, alu_shifter: combinational SLL/SRL/SRA barrel shifter parameterized by width, instantiated once.

Test Plan:
- ADD and SUB:
  - rs1=0x5, rs2_MUX=0x3, ALUCtrl=0010, in_valid=1 -> next cycle alu_out=0x8, zero=0, lt=0, ltu=0, out_valid=1.
  - rs1=0xA, rs2_MUX=0x3, ALUCtrl=0110 -> alu_out=0x7.
  - rs1=rs2_MUX=0xA, ALUCtrl=0110 -> alu_out=0, zero=1.
- Logic ops, rs1=0xF0F0F0F0, rs2_MUX=0x0F0F0F0F:
  - AND -> 0x00000000, zero=1.
  - OR -> 0xFFFFFFFF.
  - XOR with rs1=0xAAAAAAAA, rs2_MUX=0x55555555 -> 0xFFFFFFFF.
- Shifts:
  - SLL 0x1 by 4 -> 0x10.
  - SRL 0x80000000 by 1 -> 0x40000000.
  - SRA 0x80000000 by 1 -> 0xC0000000.
  - SLL 0x1 with rs2_MUX=0x21 -> 0x2.
- Compares:
  - SLT rs1=0xFFFFFFFE, rs2_MUX=0x1 -> alu_out=1, lt=1, ltu=0.
  - SLTU rs1=0x1, rs2_MUX=0xFFFFFFFF -> alu_out=1, lt=0, ltu=1.
- Default/hold/reset:
  - ALUCtrl=1111 -> alu_out=0, zero=1.
  - in_valid=0 -> outputs hold, out_valid=0.
  - Assert rst asynchronously mid-cycle -> alu_out=0, zero=1, out_valid=0 without waiting for clk.
- With ALU_MUL_EN:
  - MUL 0xFFFFFFFF×0x2 -> 0xFFFFFFFE.
  - MULH -> 0xFFFFFFFF.
  - MULHU -> 0x00000001.
  - Without the macro, MUL -> 0.
